// File: rtl/scoreboard_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// scoreboard_hazard_ctrl
//
// Per-register write scoreboard sitting beside decode. Tracks in-flight writes
// from fixed-latency units (ALU, LOAD, MUL) and one variable-latency iterative
// divider, and derives the decode stall, per-source forward selects and the
// divider structural hazard.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   issue_*           instruction currently in decode (class, sources, dest)
//   issue_kill        decode instruction flushed; never allocates
//   pipe_stall        downstream stall; freezes countdown and age fields
//   div_done          divider result forwardable this cycle
//   wb_valid, wb_rd   register-file write, retires the matching entry
//   stall_issue       hold PC and IF/ID, bubble into ID/EX (combinational)
//   fwd_rs1, fwd_rs2  forward select: 0=RS, 1=EX, 2=MEM, 3=WB (combinational)
//   div_busy          divider occupied (registered)
//   pending_cnt       number of pending entries (registered)
// -----------------------------------------------------------------------------
module scoreboard_hazard_ctrl #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned REG_W    = 5,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned MUL_LAT  = 3,
    parameter int unsigned CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [1:0]       issue_class,
    input  logic [REG_W-1:0] issue_rs1,
    input  logic [REG_W-1:0] issue_rs2,
    input  logic             issue_rs1_used,
    input  logic             issue_rs2_used,
    input  logic [REG_W-1:0] issue_rd,
    input  logic             issue_wr_rd,
    input  logic             issue_kill,
    input  logic             pipe_stall,
    input  logic             div_done,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    output logic             stall_issue,
    output logic [1:0]       fwd_rs1,
    output logic [1:0]       fwd_rs2,
    output logic             div_busy,
    output logic [REG_W:0]   pending_cnt
);

    localparam logic [1:0] CLS_ALU  = 2'd0;
    localparam logic [1:0] CLS_LOAD = 2'd1;
    localparam logic [1:0] CLS_MUL  = 2'd2;
    localparam logic [1:0] CLS_DIV  = 2'd3;

    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] MUL_CNT  = CNT_W'(MUL_LAT - 1);

    // Scoreboard state; entry 0 is never written and stays at its reset value.
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [NUM_REGS-1:0] is_div_q, is_div_d;
    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [1:0]          age_q [NUM_REGS];
    logic [1:0]          age_d [NUM_REGS];
    logic                div_busy_q, div_busy_d;
    logic [REG_W:0]      pend_cnt_d;

    logic rs1_hazard, rs2_hazard, waw_hazard, struct_hazard;
    logic issue_fire, alloc;
    logic [CNT_W-1:0] alloc_cnt;

    // An entry is "not yet forwardable" while its countdown runs or the divider owns it.
    assign rs1_hazard = issue_rs1_used & pend_q[issue_rs1] &
                        ((cnt_q[issue_rs1] != '0) | is_div_q[issue_rs1]);
    assign rs2_hazard = issue_rs2_used & pend_q[issue_rs2] &
                        ((cnt_q[issue_rs2] != '0) | is_div_q[issue_rs2]);
    assign waw_hazard = issue_wr_rd & pend_q[issue_rd] &
                        ((cnt_q[issue_rd] != '0) | is_div_q[issue_rd]);
    // div_busy is taken from state, so a DIV waits one cycle after div_done.
    assign struct_hazard = (issue_class == CLS_DIV) & div_busy_q;

    assign stall_issue = issue_valid & ~issue_kill &
                         (rs1_hazard | rs2_hazard | waw_hazard | struct_hazard);

    assign issue_fire = issue_valid & ~issue_kill & ~stall_issue & ~pipe_stall;
    assign alloc      = issue_fire & issue_wr_rd & (issue_rd != '0);

    always_comb begin
        alloc_cnt = '0;
        unique case (issue_class)
            CLS_ALU:  alloc_cnt = '0;
            CLS_LOAD: alloc_cnt = LOAD_CNT;
            CLS_MUL:  alloc_cnt = MUL_CNT;
            CLS_DIV:  alloc_cnt = '0;  // ignored while is_div is set
            default:  alloc_cnt = '0;
        endcase
    end

    // Age counts pipeline stages since issue; select is age+1, clamped at WB.
    function automatic logic [1:0] fwd_sel(input logic             used,
                                           input logic             pend,
                                           input logic [CNT_W-1:0] cnt,
                                           input logic             is_div,
                                           input logic [1:0]       age);
        if (used && pend && (cnt == '0) && !is_div) begin
            return (age == 2'd3) ? 2'd3 : age + 2'd1;
        end
        return 2'd0;
    endfunction

    assign fwd_rs1 = fwd_sel(issue_rs1_used, pend_q[issue_rs1], cnt_q[issue_rs1],
                             is_div_q[issue_rs1], age_q[issue_rs1]);
    assign fwd_rs2 = fwd_sel(issue_rs2_used, pend_q[issue_rs2], cnt_q[issue_rs2],
                             is_div_q[issue_rs2], age_q[issue_rs2]);

    always_comb begin
        pend_d     = pend_q;
        is_div_d   = is_div_q;
        cnt_d      = cnt_q;
        age_d      = age_q;
        div_busy_d = div_busy_q;

        for (int i = 1; i < int'(NUM_REGS); i++) begin
            if (pend_q[i] && !pipe_stall) begin
                if (!is_div_q[i] && (cnt_q[i] != '0)) begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
                if (age_q[i] != 2'd3) begin
                    age_d[i] = age_q[i] + 2'd1;
                end
            end
            // Divider completion and writeback are not frozen by pipe_stall.
            if (div_done && is_div_q[i]) begin
                cnt_d[i]    = '0;
                is_div_d[i] = 1'b0;
            end
            if (wb_valid && (wb_rd == REG_W'(i))) begin
                pend_d[i] = 1'b0;
            end
        end

        if (div_done) begin
            div_busy_d = 1'b0;
        end

        // Allocation last so a same-cycle writeback of the same register loses.
        if (alloc) begin
            pend_d[issue_rd]   = 1'b1;
            age_d[issue_rd]    = 2'd0;
            cnt_d[issue_rd]    = alloc_cnt;
            is_div_d[issue_rd] = (issue_class == CLS_DIV);
        end
        if (issue_fire && (issue_class == CLS_DIV)) begin
            div_busy_d = 1'b1;
        end
    end

    always_comb begin
        pend_cnt_d = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            pend_cnt_d = pend_cnt_d + {{REG_W{1'b0}}, pend_d[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            is_div_q    <= '0;
            div_busy_q  <= 1'b0;
            pending_cnt <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                cnt_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            pend_q      <= pend_d;
            is_div_q    <= is_div_d;
            div_busy_q  <= div_busy_d;
            pending_cnt <= pend_cnt_d;
            cnt_q       <= cnt_d;
            age_q       <= age_d;
        end
    end

    assign div_busy = div_busy_q;

endmodule

// File: tb/tb_scoreboard_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scoreboard_hazard_ctrl
//
// Directed scenarios followed by randomized traffic. Every cycle the DUT
// outputs are compared against a reference model that keeps, per register,
// remaining latency and elapsed stages as plain integers.
// -----------------------------------------------------------------------------
module tb_scoreboard_hazard_ctrl;

    localparam int LOAD_LAT = 2;
    localparam int MUL_LAT  = 3;

    localparam logic [1:0] ALU  = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] MUL  = 2'd2;
    localparam logic [1:0] DIV  = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid;
    logic [1:0] issue_class;
    logic [4:0] issue_rs1, issue_rs2, issue_rd, wb_rd;
    logic       issue_rs1_used, issue_rs2_used, issue_wr_rd;
    logic       issue_kill, pipe_stall, div_done, wb_valid;
    logic       stall_issue, div_busy;
    logic [1:0] fwd_rs1, fwd_rs2;
    logic [5:0] pending_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model state.
    int m_pend [32];
    int m_rem  [32];
    int m_age  [32];
    int m_div  [32];
    bit m_busy;

    always #5 clk = ~clk;

    scoreboard_hazard_ctrl #(
        .NUM_REGS(32),
        .REG_W   (5),
        .LOAD_LAT(LOAD_LAT),
        .MUL_LAT (MUL_LAT),
        .CNT_W   (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_class   (issue_class),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_rs1_used(issue_rs1_used),
        .issue_rs2_used(issue_rs2_used),
        .issue_rd      (issue_rd),
        .issue_wr_rd   (issue_wr_rd),
        .issue_kill    (issue_kill),
        .pipe_stall    (pipe_stall),
        .div_done      (div_done),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .stall_issue   (stall_issue),
        .fwd_rs1       (fwd_rs1),
        .fwd_rs2       (fwd_rs2),
        .div_busy      (div_busy),
        .pending_cnt   (pending_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int r = 0; r < 32; r++) begin
            m_pend[r] = 0;
            m_rem[r]  = 0;
            m_age[r]  = 0;
            m_div[r]  = 0;
        end
        m_busy = 1'b0;
    endtask

    function automatic bit m_hz(input int r);
        return (m_pend[r] != 0) && ((m_rem[r] > 0) || (m_div[r] != 0));
    endfunction

    function automatic bit m_stall();
        bit raw, waw, st;
        raw = (issue_rs1_used && m_hz(int'(issue_rs1))) ||
              (issue_rs2_used && m_hz(int'(issue_rs2)));
        waw = issue_wr_rd && m_hz(int'(issue_rd));
        st  = (issue_class == DIV) && m_busy;
        return issue_valid && !issue_kill && (raw || waw || st);
    endfunction

    function automatic int m_fwd(input bit used, input int r);
        if (used && (r != 0) && (m_pend[r] != 0) && (m_rem[r] == 0) && (m_div[r] == 0)) begin
            return (m_age[r] >= 2) ? 3 : m_age[r] + 1;
        end
        return 0;
    endfunction

    function automatic int m_count();
        int c;
        c = 0;
        for (int r = 0; r < 32; r++) c += (m_pend[r] != 0) ? 1 : 0;
        return c;
    endfunction

    // Advance the model across one rising edge using the inputs held before it.
    task automatic m_edge();
        bit fire;
        fire = issue_valid && !issue_kill && !m_stall() && !pipe_stall;
        for (int r = 1; r < 32; r++) begin
            if ((m_pend[r] != 0) && !pipe_stall) begin
                if ((m_div[r] == 0) && (m_rem[r] > 0)) m_rem[r]--;
                m_age[r]++;
            end
            if (div_done && (m_div[r] != 0)) begin
                m_rem[r] = 0;
                m_div[r] = 0;
            end
            if (wb_valid && (int'(wb_rd) == r)) m_pend[r] = 0;
        end
        if (div_done) m_busy = 1'b0;
        if (fire && issue_wr_rd && (issue_rd != 5'd0)) begin
            m_pend[issue_rd] = 1;
            m_age[issue_rd]  = 0;
            m_div[issue_rd]  = (issue_class == DIV) ? 1 : 0;
            case (issue_class)
                LOAD:    m_rem[issue_rd] = LOAD_LAT - 1;
                MUL:     m_rem[issue_rd] = MUL_LAT - 1;
                default: m_rem[issue_rd] = 0;
            endcase
        end
        if (fire && (issue_class == DIV)) m_busy = 1'b1;
    endtask

    task automatic drive(input bit v, input logic [1:0] cls, input int r1, input bit u1,
                         input int r2, input bit u2, input int d, input bit w);
        issue_valid    = v;
        issue_class    = cls;
        issue_rs1      = 5'(r1);
        issue_rs1_used = u1;
        issue_rs2      = 5'(r2);
        issue_rs2_used = u2;
        issue_rd       = 5'(d);
        issue_wr_rd    = w;
        issue_kill     = 1'b0;
        pipe_stall     = 1'b0;
        div_done       = 1'b0;
        wb_valid       = 1'b0;
        wb_rd          = 5'd0;
    endtask

    task automatic idle();
        drive(1'b0, ALU, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic settle();
        #1;
    endtask

    // Compare all outputs with the model, then step one clock.
    task automatic cyc();
        chk("stall_issue", 32'(stall_issue), 32'(m_stall()));
        chk("fwd_rs1", 32'(fwd_rs1), 32'(m_fwd(issue_rs1_used, int'(issue_rs1))));
        chk("fwd_rs2", 32'(fwd_rs2), 32'(m_fwd(issue_rs2_used, int'(issue_rs2))));
        chk("div_busy", 32'(div_busy), 32'(m_busy));
        chk("pending_cnt", 32'(pending_cnt), 32'(m_count()));
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        m_reset();
        @(negedge clk);
        @(negedge clk);
        settle();
        chk("rst_stall", 32'(stall_issue), 32'd0);
        chk("rst_fwd_rs1", 32'(fwd_rs1), 32'd0);
        chk("rst_fwd_rs2", 32'(fwd_rs2), 32'd0);
        chk("rst_div_busy", 32'(div_busy), 32'd0);
        chk("rst_pending", 32'(pending_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back ALU and one-apart forwarding.
        drive(1, ALU, 1, 1, 2, 1, 5, 1); settle();
        chk("alu_first_stall", 32'(stall_issue), 32'd0);
        cyc();
        drive(1, ALU, 5, 1, 0, 0, 6, 1); settle();
        chk("alu_b2b_stall", 32'(stall_issue), 32'd0);
        chk("alu_b2b_fwd_ex", 32'(fwd_rs1), 32'd1);
        cyc();
        drive(1, ALU, 6, 1, 5, 1, 11, 1); settle();
        chk("alu_b2b_fwd_ex2", 32'(fwd_rs1), 32'd1);
        chk("alu_gap_fwd_mem", 32'(fwd_rs2), 32'd2);
        cyc();
        idle(); wb_valid = 1'b1; wb_rd = 5'd5; settle();
        chk("alu_pending3", 32'(pending_cnt), 32'd3);
        cyc();
        idle(); wb_valid = 1'b1; wb_rd = 5'd6; settle(); cyc();
        idle(); wb_valid = 1'b1; wb_rd = 5'd11; settle(); cyc();
        idle(); settle();
        chk("wb_pending0", 32'(pending_cnt), 32'd0);
        cyc();

        // LOAD-use: one stall cycle, then MEM forward.
        drive(1, LOAD, 0, 0, 0, 0, 7, 1); settle(); cyc();
        drive(1, ALU, 7, 1, 0, 0, 12, 0); settle();
        chk("load_use_stall", 32'(stall_issue), 32'd1);
        cyc();
        drive(1, ALU, 7, 1, 0, 0, 12, 0); settle();
        chk("load_use_go", 32'(stall_issue), 32'd0);
        chk("load_use_fwd_mem", 32'(fwd_rs1), 32'd2);
        cyc();

        // LOAD-use with three pipe_stall cycles: four stall cycles total.
        drive(1, LOAD, 0, 0, 0, 0, 13, 1); settle(); cyc();
        for (int k = 0; k < 3; k++) begin
            drive(1, ALU, 13, 1, 0, 0, 12, 0); pipe_stall = 1'b1; settle();
            chk("load_pstall_stall", 32'(stall_issue), 32'd1);
            cyc();
        end
        drive(1, ALU, 13, 1, 0, 0, 12, 0); settle();
        chk("load_pstall_stall4", 32'(stall_issue), 32'd1);
        cyc();
        drive(1, ALU, 13, 1, 0, 0, 12, 0); settle();
        chk("load_pstall_go", 32'(stall_issue), 32'd0);
        chk("load_pstall_fwd", 32'(fwd_rs1), 32'd2);
        cyc();

        // MUL-use: two stall cycles, then WB forward.
        drive(1, MUL, 0, 0, 0, 0, 8, 1); settle(); cyc();
        for (int k = 0; k < 2; k++) begin
            drive(1, ALU, 0, 0, 8, 1, 12, 0); settle();
            chk("mul_use_stall", 32'(stall_issue), 32'd1);
            cyc();
        end
        drive(1, ALU, 0, 0, 8, 1, 12, 0); settle();
        chk("mul_use_go", 32'(stall_issue), 32'd0);
        chk("mul_use_fwd_wb", 32'(fwd_rs2), 32'd3);
        cyc();

        // Divider: dependent stall, structural stall, release on div_done.
        drive(1, DIV, 1, 1, 2, 1, 9, 1); settle();
        chk("div_issue", 32'(stall_issue), 32'd0);
        cyc();
        for (int k = 0; k < 2; k++) begin
            drive(1, ALU, 9, 1, 0, 0, 17, 1); settle();
            chk("div_raw_stall", 32'(stall_issue), 32'd1);
            chk("div_busy_set", 32'(div_busy), 32'd1);
            cyc();
        end
        drive(1, DIV, 3, 1, 4, 1, 14, 1); div_done = 1'b1; settle();
        chk("div_done_same_cycle_stall", 32'(stall_issue), 32'd1);
        chk("div_done_busy_still", 32'(div_busy), 32'd1);
        cyc();
        drive(1, DIV, 3, 1, 4, 1, 14, 1); settle();
        chk("div2_issue", 32'(stall_issue), 32'd0);
        chk("div_busy_cleared", 32'(div_busy), 32'd0);
        cyc();
        drive(1, ALU, 9, 1, 0, 0, 17, 1); settle();
        chk("div_dep_go", 32'(stall_issue), 32'd0);
        chk("div_dep_fwd", 32'(fwd_rs1), 32'd3);
        chk("div2_busy", 32'(div_busy), 32'd1);
        cyc();
        drive(1, ALU, 17, 1, 0, 0, 9, 1); wb_valid = 1'b1; wb_rd = 5'd9; settle();
        chk("wb_realloc_stall", 32'(stall_issue), 32'd0);
        chk("wb_realloc_fwd", 32'(fwd_rs1), 32'd1);
        cyc();
        drive(1, ALU, 9, 1, 0, 0, 0, 0); settle();
        chk("realloc_wins_fwd", 32'(fwd_rs1), 32'd1);
        cyc();
        idle(); div_done = 1'b1; settle(); cyc();

        // Kill with a RAW hazard present; x0 operands.
        drive(1, MUL, 0, 0, 0, 0, 15, 1); settle(); cyc();
        drive(1, ALU, 15, 1, 0, 0, 16, 1); issue_kill = 1'b1; settle();
        chk("kill_no_stall", 32'(stall_issue), 32'd0);
        chk("kill_pending_before", 32'(pending_cnt), 32'd7);
        cyc();
        drive(1, ALU, 16, 1, 0, 0, 0, 0); settle();
        chk("kill_no_alloc_fwd", 32'(fwd_rs1), 32'd0);
        chk("kill_pending_after", 32'(pending_cnt), 32'd7);
        cyc();
        drive(1, ALU, 0, 1, 0, 1, 0, 1); settle();
        chk("x0_stall", 32'(stall_issue), 32'd0);
        chk("x0_fwd_rs1", 32'(fwd_rs1), 32'd0);
        chk("x0_fwd_rs2", 32'(fwd_rs2), 32'd0);
        cyc();
        idle(); settle();
        chk("x0_no_alloc", 32'(pending_cnt), 32'd7);
        cyc();

        // Randomized traffic over a small register window.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            issue_kill = ($urandom_range(0, 7) == 0);
            pipe_stall = ($urandom_range(0, 7) == 0);
            div_done   = m_busy && ($urandom_range(0, 5) == 0);
            wb_valid   = ($urandom_range(0, 2) == 0);
            wb_rd      = 5'($urandom_range(0, 7));
            settle();
            cyc();
        end

        // Asynchronous reset in the middle of a divide with four pending entries.
        idle();
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, DIV, 0, 0, 0, 0, 1, 1); settle(); cyc();
        drive(1, ALU, 0, 0, 0, 0, 2, 1); settle(); cyc();
        drive(1, ALU, 0, 0, 0, 0, 3, 1); settle(); cyc();
        drive(1, LOAD, 0, 0, 0, 0, 4, 1); settle(); cyc();
        drive(1, DIV, 2, 1, 4, 1, 5, 1); settle();
        chk("pre_rst_pending", 32'(pending_cnt), 32'd4);
        chk("pre_rst_busy", 32'(div_busy), 32'd1);
        chk("pre_rst_stall", 32'(stall_issue), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(div_busy), 32'd0);
        chk("async_rst_pending", 32'(pending_cnt), 32'd0);
        chk("async_rst_stall", 32'(stall_issue), 32'd0);
        chk("async_rst_fwd", 32'(fwd_rs1), 32'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
